// File: rtl/gj_axis_uart_rx.sv
// AXI-Stream UART receiver: oversampled start/data/parity/stop decoding with
// optional idle-gap frame tagging (tlast) and a power-down readiness flag.
module gj_axis_uart_rx #(
  parameter int OVS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [3:0]  mode,
  input  logic [15:0] rxFrame_gap,
  input  logic        rx,
  output logic        rx_tvalid,
  input  logic        rx_tready,
  output logic [7:0]  rx_tdata,
  output logic        rx_tlast,
  output logic [1:0]  rx_tuser,
  output logic        rx_overrun,
  output logic        rxEn,
  input  logic        powerDown_tvalid,
  output logic        powerDown_tready
);
  localparam int TCW = $clog2(OVS);
  localparam int GW  = 16 + TCW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t          state;
  logic            rx_m, rx_s;
  logic [TCW-1:0]  tc;
  logic [2:0]      bc;
  logic [3:0]      mode_q;
  logic [7:0]      shreg;
  logic            perr, ferr;
  logic            pend_vld;
  logic [7:0]      pend_data;
  logic [1:0]      pend_user;
  logic [GW-1:0]   gap_cnt;

  logic            tick_half, tick_bit, confirm, done, done_ferr, gap_exp, par_bad;
  logic [GW-1:0]   gap_lim;
  logic            ld_req, ld_pend, ld_last, ld_ok;
  logic [7:0]      ld_data;
  logic [1:0]      ld_user;
  logic            unused_pd;

  assign unused_pd        = powerDown_tvalid;
  assign powerDown_tready = (state == IDLE) && !pend_vld && !rx_tvalid;

  always_comb begin
    tick_half = clk_en && (tc == TCW'(OVS/2 - 1));
    tick_bit  = clk_en && (tc == TCW'(OVS - 1));
    confirm   = (state == START) && tick_half && !rx_s;
    done      = (state == STOP) && tick_bit && (mode_q[0] || bc == 3'd1);
    done_ferr = ferr | ~rx_s;
    par_bad   = (mode_q[2] ? ~^shreg : ^shreg) != rx_s;
    gap_lim   = GW'(OVS) * GW'((rxFrame_gap == 16'd0) ? 16'd1 : rxFrame_gap);
    // a start edge on the same tick as gap expiry wins: the byte goes out untagged
    gap_exp   = (state == IDLE) && pend_vld && clk_en && rx_s && (gap_cnt == gap_lim - 1'b1);
    ld_pend   = pend_vld && (confirm || gap_exp);
    ld_req    = 1'b0;
    ld_data   = shreg;
    ld_last   = 1'b0;
    ld_user   = {done_ferr, perr};
    if (done && !mode_q[3]) begin
      ld_req = 1'b1;
    end else if (ld_pend) begin
      ld_req  = 1'b1;
      ld_data = pend_data;
      ld_user = pend_user;
      ld_last = gap_exp;
    end
    ld_ok = !rx_tvalid || rx_tready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      tc         <= '0;
      bc         <= '0;
      mode_q     <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      pend_vld   <= 1'b0;
      pend_data  <= '0;
      pend_user  <= '0;
      gap_cnt    <= '0;
      rx_tvalid  <= 1'b0;
      rx_tdata   <= '0;
      rx_tlast   <= 1'b0;
      rx_tuser   <= '0;
      rx_overrun <= 1'b0;
      rxEn       <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_overrun <= 1'b0;

      if (rx_tvalid && rx_tready) rx_tvalid <= 1'b0;
      // a byte that cannot be placed is lost; the output register is never overwritten
      if (ld_req) begin
        if (ld_ok) begin
          rx_tvalid <= 1'b1;
          rx_tdata  <= ld_data;
          rx_tlast  <= ld_last;
          rx_tuser  <= ld_user;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
      if (ld_pend) pend_vld <= 1'b0;
      if (done && mode_q[3]) begin
        pend_vld  <= 1'b1;
        pend_data <= shreg;
        pend_user <= {done_ferr, perr};
      end

      if (done || (state == IDLE && clk_en && !rx_s)) gap_cnt <= '0;
      else if (state == IDLE && clk_en && gap_cnt != '1) gap_cnt <= gap_cnt + 1'b1;

      if (clk_en) begin
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            tc    <= '0;
          end
          START: if (tick_half) begin
            tc <= '0;
            if (!rx_s) begin
              state  <= DATA;
              rxEn   <= 1'b1;
              mode_q <= mode;
              bc     <= '0;
              perr   <= 1'b0;
              ferr   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else tc <= tc + 1'b1;
          DATA: if (tick_bit) begin
            tc    <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bc    <= bc + 1'b1;
            if (bc == 3'd7) state <= (mode_q[1] | mode_q[2]) ? PARITY : STOP;
          end else tc <= tc + 1'b1;
          PARITY: if (tick_bit) begin
            tc    <= '0;
            perr  <= par_bad;
            state <= STOP;
          end else tc <= tc + 1'b1;
          STOP: if (tick_bit) begin
            tc   <= '0;
            bc   <= bc + 1'b1;
            ferr <= done_ferr;
            if (done) begin
              rxEn  <= 1'b0;
              state <= (done_ferr && shreg == 8'd0) ? BREAK : IDLE;
            end
          end else tc <= tc + 1'b1;
          BREAK: if (rx_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gj_axis_uart_rx.sv
// Directed bench for gj_axis_uart_rx: frames driven bit by bit, beats captured
// by a monitor and compared against hand-computed bytes, flags and timings.
module tb_gj_axis_uart_rx;
  localparam int OVS = 16;

  logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1, rx = 1'b1;
  logic [3:0]  mode = 4'b0001;
  logic [15:0] rxFrame_gap = 16'd3;
  logic        rx_tvalid, rx_tready = 1'b1, rx_tlast, rx_overrun, rxEn;
  logic [7:0]  rx_tdata;
  logic [1:0]  rx_tuser;
  logic        powerDown_tvalid = 1'b0, powerDown_tready;

  int checks = 0, errors = 0, cyc = 0, en_cnt = 0, ovr_cnt = 0, en_fall = 0;
  logic en_d = 1'b0;

  typedef struct {logic [7:0] d; logic l; logic [1:0] u; logic en; int c;} beat_t;
  beat_t q[$];

  gj_axis_uart_rx #(.OVS(OVS)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .mode(mode), .rxFrame_gap(rxFrame_gap),
    .rx(rx), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser), .rx_overrun(rx_overrun), .rxEn(rxEn),
    .powerDown_tvalid(powerDown_tvalid), .powerDown_tready(powerDown_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    beat_t b;
    if (rx_tvalid && rx_tready) begin
      b.d = rx_tdata; b.l = rx_tlast; b.u = rx_tuser; b.en = rxEn; b.c = cyc;
      q.push_back(b);
    end
    if (rx_overrun) ovr_cnt++;
    if (rxEn) en_cnt++;
    if (en_d && !rxEn) en_fall = cyc;
    en_d = rxEn;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  function automatic logic [31:0] outv();
    return 32'({rx_tvalid, rx_tdata, rx_tlast, rx_tuser, rx_overrun, rxEn, powerDown_tready});
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par, input int nstop);
    rx = 1'b0; step(OVS);
    for (int i = 0; i < 8; i++) begin rx = d[i]; step(OVS); end
    if (has_par) begin rx = par; step(OVS); end
    for (int i = 0; i < nstop; i++) begin rx = 1'b1; step(OVS); end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [7:0] d, input logic l, input logic [1:0] u);
    if (q.size() <= idx) chk({tag, "_cnt"}, 32'(q.size()), 32'(idx + 1));
    else begin
      chk({tag, "_data"}, 32'(q[idx].d), 32'(d));
      chk({tag, "_last"}, 32'(q[idx].l), 32'(l));
      chk({tag, "_user"}, 32'(q[idx].u), 32'(u));
    end
  endtask

  initial begin
    step(3); rst = 1'b0; step(2);
    chk("rst_out", outv(), 32'h1);

    // 8N1 byte
    q.delete(); en_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b0, 1); step(32);
    chk("t1_n", 32'(q.size()), 1);
    chk_beat("t1", 0, 8'hA5, 1'b0, 2'b00);
    chk("t1_en", 32'(en_cnt >= 140 && en_cnt <= 156), 1);

    // even parity with wrong bit, odd parity with right bit
    mode = 4'b0011; q.delete();
    send_frame(8'hA5, 1'b1, 1'b1, 1); step(32);
    chk_beat("t2e", 0, 8'hA5, 1'b0, 2'b01);
    mode = 4'b0101; q.delete();
    send_frame(8'hA5, 1'b1, 1'b1, 1); step(32);
    chk_beat("t2o", 0, 8'hA5, 1'b0, 2'b00);

    // idle-gap framing, gap = 3 bit times
    mode = 4'b1001; rxFrame_gap = 16'd3; q.delete();
    send_frame(8'h11, 1'b0, 1'b0, 1);
    chk("t3_hold", 32'(q.size()), 0);
    chk("t3_pd_pend", 32'(powerDown_tready), 0);
    send_frame(8'h22, 1'b0, 1'b0, 1); step(96);
    chk("t3_n", 32'(q.size()), 2);
    chk_beat("t3a", 0, 8'h11, 1'b0, 2'b00);
    chk_beat("t3b", 1, 8'h22, 1'b1, 2'b00);
    if (q.size() == 2) begin
      chk("t3_rel_at_start", 32'(q[0].en), 1);
      chk("t3_gap", 32'(q[1].c - en_fall), 48);
    end
    chk("t3_pd", 32'(powerDown_tready), 1);

    // gap of 0 behaves as 1 bit time
    rxFrame_gap = 16'd0; q.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1); step(48);
    chk_beat("t3z", 0, 8'h3C, 1'b1, 2'b00);
    if (q.size() == 1) chk("t3z_gap", 32'(q[0].c - en_fall), 16);

    // backpressure: second byte dropped
    mode = 4'b0001; rx_tready = 1'b0; q.delete(); ovr_cnt = 0;
    send_frame(8'h11, 1'b0, 1'b0, 1);
    send_frame(8'h33, 1'b0, 1'b0, 1); step(32);
    chk("t4_valid", 32'(rx_tvalid), 1);
    chk("t4_data", 32'(rx_tdata), 32'h11);
    chk("t4_ovr", 32'(ovr_cnt), 1);
    chk("t4_pd", 32'(powerDown_tready), 0);
    rx_tready = 1'b1; step(8);
    chk("t4_n", 32'(q.size()), 1);
    chk_beat("t4", 0, 8'h11, 1'b0, 2'b00);
    chk("t4_drain", 32'(rx_tvalid), 0);

    // glitch, then break
    q.delete(); en_cnt = 0;
    rx = 1'b0; step(4); rx = 1'b1; step(48);
    chk("t5_glitch_n", 32'(q.size()), 0);
    chk("t5_glitch_en", 32'(en_cnt), 0);
    rx = 1'b0; step(20 * OVS);
    chk("t5_brk_n", 32'(q.size()), 1);
    chk_beat("t5", 0, 8'h00, 1'b0, 2'b10);
    chk("t5_pd_brk", 32'(powerDown_tready), 0);
    rx = 1'b1; step(32);
    chk("t5_after_n", 32'(q.size()), 1);
    chk("t5_pd", 32'(powerDown_tready), 1);

    // reset discards pending byte
    mode = 4'b1001; rxFrame_gap = 16'd100; q.delete();
    send_frame(8'h77, 1'b0, 1'b0, 1); step(16);
    chk("t6_pend_pd", 32'(powerDown_tready), 0);
    rst = 1'b1; step(1);
    chk("t6_rst_out", outv(), 32'h1);
    rst = 1'b0; mode = 4'b0001; step(110 * OVS);
    chk("t6_pend_gone", 32'(q.size()), 0);

    // reset mid-data, then a clean byte
    rx = 1'b0; step(OVS); step(40);
    chk("t6_mid_en", 32'(rxEn), 1);
    rst = 1'b1; rx = 1'b1; step(1);
    chk("t6_mid_rst", outv(), 32'h1);
    rst = 1'b0; step(32);
    chk("t6_quiet", outv(), 32'h1);
    send_frame(8'h5A, 1'b0, 1'b0, 1); step(32);
    chk("t6_n", 32'(q.size()), 1);
    chk_beat("t6", 0, 8'h5A, 1'b0, 2'b00);
    chk("t6_pd", 32'(powerDown_tready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
